dnmr_manager: RTL and testbench



---
 rtl/dnmr_pkg.sv | 21 ++
 rtl/dnmr_fault_tracker.sv | 57 +++++
 rtl/dnmr_manager.sv | 214 +++++++++++++++++++++
 tb/tb_dnmr_manager.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dnmr_pkg.sv
// -----------------------------------------------------------------------------
// dnmr_pkg
// Shared definitions for the dynamic N-modular redundancy manager.
//   dnmr_state_t : manager operating mode, also driven out on mode_o
//   CNT_INC      : fault counter step when a replica disagrees with the vote
//   CNT_DEC      : fault counter leak when a replica agrees with the vote
// -----------------------------------------------------------------------------
package dnmr_pkg;

    typedef enum logic [2:0] {
        ST_SIMPLEX = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_VOTE    = 3'd2,
        ST_DUPLEX  = 3'd3,
        ST_FAIL    = 3'd4
    } dnmr_state_t;

    localparam int CNT_INC = 2;
    localparam int CNT_DEC = 1;

endpackage

// File: rtl/dnmr_fault_tracker.sv
// -----------------------------------------------------------------------------
// dnmr_fault_tracker
// Leaky saturating disagreement counter plus sticky health bit for one replica.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   disagree   : replica output differs from the vote this cycle
//   count_en   : counting allowed (manager is voting)
//   clear      : restore the replica to healthy with a zero count
//   o_healthy  : replica is still trusted
//   o_retire   : this edge will retire the replica (combinational look-ahead)
// -----------------------------------------------------------------------------
module dnmr_fault_tracker #(
    parameter int FAULT_TH = 8,
    parameter int CW       = $clog2(FAULT_TH + 2)
) (
    input  logic clk,
    input  logic rst,
    input  logic disagree,
    input  logic count_en,
    input  logic clear,
    output logic o_healthy,
    output logic o_retire
);
    import dnmr_pkg::*;

    logic [CW-1:0] r_cnt;
    logic          r_healthy;
    logic [CW:0]   w_cnt_next;

    // One spare bit keeps the post-increment value exact before the
    // threshold compare; the counter itself never exceeds FAULT_TH+1.
    always_comb begin
        w_cnt_next = '0;
        if (disagree) begin
            w_cnt_next = {1'b0, r_cnt} + (CW+1)'(CNT_INC);
        end else if (r_cnt >= CW'(CNT_DEC)) begin
            w_cnt_next = {1'b0, r_cnt} - (CW+1)'(CNT_DEC);
        end
    end

    assign o_retire  = count_en && r_healthy && (w_cnt_next >= (CW+1)'(FAULT_TH));
    assign o_healthy = r_healthy;

    // A retired replica freezes its count until cleared.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt     <= '0;
            r_healthy <= 1'b1;
        end else if (count_en && r_healthy) begin
            r_cnt <= w_cnt_next[CW-1:0];
            if (o_retire) begin
                r_healthy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dnmr_manager.sv
// -----------------------------------------------------------------------------
// dnmr_manager
// Dynamic N-modular redundancy manager: enables one or all healthy replicas,
// votes their outputs bitwise, retires replicas that keep disagreeing and
// degrades VOTE -> DUPLEX -> SIMPLEX/FAIL.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   hr_req        : request redundant operation
//   clear_faults  : pulse, restore every replica to healthy
//   rep_data      : replica outputs, replica i at [i*W +: W]
//   en            : replica enables (decode of state and health mask)
//   data_o        : registered voted/selected data
//   valid_o       : data_o is trustworthy
//   miscompare    : registered DUPLEX disagreement
//   healthy       : per-replica health mask
//   fault_irq     : one-cycle pulse when a replica is newly retired
//   mode_o        : current state code
// -----------------------------------------------------------------------------
module dnmr_manager #(
    parameter int N          = 3,
    parameter int W          = 8,
    parameter int FAULT_TH   = 8,
    parameter int WARMUP_CYC = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hr_req,
    input  logic           clear_faults,
    input  logic [N*W-1:0] rep_data,
    output logic [N-1:0]   en,
    output logic [W-1:0]   data_o,
    output logic           valid_o,
    output logic           miscompare,
    output logic [N-1:0]   healthy,
    output logic           fault_irq,
    output logic [2:0]     mode_o
);
    import dnmr_pkg::*;

    localparam int CW  = $clog2(FAULT_TH + 2);
    localparam int HW  = $clog2(N + 1);
    localparam int PW  = (N > 1) ? $clog2(N) : 1;
    localparam int WCW = $clog2(WARMUP_CYC + 2);

    dnmr_state_t    r_state;
    logic [WCW-1:0] r_wcnt;
    logic [W-1:0]   r_data;
    logic           r_valid;
    logic           r_mis;
    logic           r_irq;

    logic [N-1:0]   w_healthy;
    logic [N-1:0]   w_retire;
    logic [N-1:0]   w_disagree;
    logic [PW-1:0]  w_prim;
    logic [PW-1:0]  w_sec;
    logic [W-1:0]   w_prim_data;
    logic [W-1:0]   w_sec_data;
    logic [HW-1:0]  w_hcnt;
    logic [HW-1:0]  w_hcnt_post;
    logic [W-1:0]   w_vote;
    logic [HW-1:0]  w_ones;

    // Primary is the lowest-index healthy replica; secondary is the highest,
    // which in DUPLEX is the other surviving replica.
    always_comb begin
        w_prim = '0;
        w_sec  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_healthy[i]) w_prim = PW'(i);
        end
        for (int i = 0; i < N; i++) begin
            if (w_healthy[i]) w_sec = PW'(i);
        end
    end

    assign w_prim_data = rep_data[int'(w_prim)*W +: W];
    assign w_sec_data  = rep_data[int'(w_sec)*W +: W];

    always_comb begin
        w_hcnt      = '0;
        w_hcnt_post = '0;
        for (int i = 0; i < N; i++) begin
            w_hcnt      = w_hcnt + HW'(w_healthy[i]);
            w_hcnt_post = w_hcnt_post + HW'(w_healthy[i] & ~w_retire[i]);
        end
    end

    // Bitwise majority over healthy replicas; an exact tie (even count)
    // falls back to the primary's bit.
    always_comb begin
        w_vote = '0;
        w_ones = '0;
        for (int b = 0; b < W; b++) begin
            w_ones = '0;
            for (int i = 0; i < N; i++) begin
                if (w_healthy[i] && rep_data[i*W + b]) w_ones = w_ones + 1'b1;
            end
            if ({w_ones, 1'b0} > {1'b0, w_hcnt}) begin
                w_vote[b] = 1'b1;
            end else if ({w_ones, 1'b0} == {1'b0, w_hcnt}) begin
                w_vote[b] = w_prim_data[b];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_track
            assign w_disagree[g] = (rep_data[g*W +: W] != w_vote);
            dnmr_fault_tracker #(
                .FAULT_TH (FAULT_TH),
                .CW       (CW)
            ) u_track (
                .clk       (clk),
                .rst       (rst),
                .disagree  (w_disagree[g]),
                .count_en  (r_state == ST_VOTE),
                .clear     (clear_faults),
                .o_healthy (w_healthy[g]),
                .o_retire  (w_retire[g])
            );
        end
    endgenerate

    // Enables follow the registered state; SIMPLEX isolates the lowest set
    // health bit so only the primary runs.
    always_comb begin
        en = '0;
        case (r_state)
            ST_SIMPLEX: en = w_healthy & ~(w_healthy - 1'b1);
            ST_WARMUP,
            ST_VOTE,
            ST_DUPLEX:  en = w_healthy;
            default:    en = '0;
        endcase
    end

    function automatic dnmr_state_t stateFromCount(input logic [HW-1:0] c);
        if (c >= HW'(3))      return ST_VOTE;
        else if (c == HW'(2)) return ST_DUPLEX;
        else if (c == HW'(1)) return ST_SIMPLEX;
        else                  return ST_FAIL;
    endfunction

    // Mode FSM with registered data/valid/miscompare/irq. clear_faults
    // overrides whatever transition the current state picked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SIMPLEX;
            r_wcnt  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_irq <= (|w_retire) && !clear_faults;
            r_mis <= 1'b0;
            case (r_state)
                ST_SIMPLEX: begin
                    r_data  <= w_prim_data;
                    r_valid <= (w_hcnt != '0);
                    if (hr_req) begin
                        r_state <= ST_WARMUP;
                        r_wcnt  <= WCW'(WARMUP_CYC);
                    end
                end
                ST_WARMUP: begin
                    r_data  <= w_prim_data;
                    r_valid <= 1'b1;
                    if (!hr_req) begin
                        r_state <= ST_SIMPLEX;
                    end else if (r_wcnt <= WCW'(1)) begin
                        r_wcnt  <= '0;
                        r_state <= (w_hcnt >= HW'(3)) ? ST_VOTE :
                                   (w_hcnt == HW'(2)) ? ST_DUPLEX : ST_SIMPLEX;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                ST_VOTE: begin
                    r_data  <= w_vote;
                    r_valid <= 1'b1;
                    r_state <= hr_req ? stateFromCount(w_hcnt_post) : ST_SIMPLEX;
                end
                ST_DUPLEX: begin
                    r_data  <= w_prim_data;
                    r_mis   <= (w_prim_data != w_sec_data);
                    r_valid <= (w_prim_data == w_sec_data);
                    if (!hr_req) r_state <= ST_SIMPLEX;
                end
                ST_FAIL: begin
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_SIMPLEX;
                    r_valid <= 1'b0;
                end
            endcase
            if (clear_faults) begin
                r_state <= ST_SIMPLEX;
                r_wcnt  <= '0;
            end
        end
    end

    assign data_o     = r_data;
    assign valid_o    = r_valid;
    assign miscompare = r_mis;
    assign fault_irq  = r_irq;
    assign healthy    = w_healthy;
    assign mode_o     = r_state;

endmodule

// File: tb/tb_dnmr_manager.sv
// -----------------------------------------------------------------------------
// tb_dnmr_manager
// Directed, table-driven bench for dnmr_manager (N=3, W=8, FAULT_TH=8,
// WARMUP_CYC=4). Each table row gives the inputs held for one clock and the
// outputs expected just after that edge.
// -----------------------------------------------------------------------------
module tb_dnmr_manager;

    logic        clk = 1'b0;
    logic        rst;
    logic        hr_req;
    logic        clear_faults;
    logic [23:0] rep_data;
    logic [2:0]  en;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        miscompare;
    logic [2:0]  healthy;
    logic        fault_irq;
    logic [2:0]  mode_o;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    dnmr_manager #(
        .N          (3),
        .W          (8),
        .FAULT_TH   (8),
        .WARMUP_CYC (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hr_req       (hr_req),
        .clear_faults (clear_faults),
        .rep_data     (rep_data),
        .en           (en),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .miscompare   (miscompare),
        .healthy      (healthy),
        .fault_irq    (fault_irq),
        .mode_o       (mode_o)
    );

    typedef struct {
        string      name;
        logic       hr;
        logic       clr;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [2:0] en;
        logic [7:0] data;
        logic       valid;
        logic       mis;
        logic [2:0] hl;
        logic       irq;
        logic [2:0] mode;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string nm, input logic hr, input logic clr,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [2:0] e, input logic [7:0] d, input logic v,
                          input logic m, input logic [2:0] h, input logic irq,
                          input logic [2:0] md);
        vec_t x;
        x.name = nm; x.hr = hr; x.clr = clr; x.r0 = a; x.r1 = b; x.r2 = c;
        x.en = e; x.data = d; x.valid = v; x.mis = m; x.hl = h; x.irq = irq; x.mode = md;
        vecs.push_back(x);
    endtask

    task automatic checkField(input string nm, input string field,
                              input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s.%s: got %0h expected %0h", nm, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string nm, input logic [2:0] e, input logic [7:0] d,
                               input logic v, input logic m, input logic [2:0] h,
                               input logic irq, input logic [2:0] md);
        checkField(nm, "en",         {5'b0, en},          {5'b0, e});
        checkField(nm, "data_o",     data_o,              d);
        checkField(nm, "valid_o",    {7'b0, valid_o},     {7'b0, v});
        checkField(nm, "miscompare", {7'b0, miscompare},  {7'b0, m});
        checkField(nm, "healthy",    {5'b0, healthy},     {5'b0, h});
        checkField(nm, "fault_irq",  {7'b0, fault_irq},   {7'b0, irq});
        checkField(nm, "mode_o",     {5'b0, mode_o},      {5'b0, md});
    endtask

    // Drive inputs away from the edge, clock once, sample 1ns after the edge.
    task automatic applyStimulus(input logic r, input logic hr, input logic clr,
                                 input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        rst          = r;
        hr_req       = hr;
        clear_faults = clr;
        rep_data     = {c, b, a};
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; hr_req = 1'b0; clear_faults = 1'b0; rep_data = '0;

        // Main sequence: simplex, warm-up, vote with retirement, duplex.
        addVec("simplex0", 0,0, 8'h5A,8'h00,8'h00, 3'b001,8'h5A,1,0,3'b111,0,3'd0);
        addVec("simplex1", 0,0, 8'h5A,8'h00,8'h00, 3'b001,8'h5A,1,0,3'b111,0,3'd0);
        addVec("to_warm",  1,0, 8'h3C,8'h3C,8'hFF, 3'b111,8'h3C,1,0,3'b111,0,3'd1);
        for (int k = 0; k < 3; k++)
            addVec("warm_a", 1,0, 8'h3C,8'h3C,8'hFF, 3'b111,8'h3C,1,0,3'b111,0,3'd1);
        addVec("to_vote",  1,0, 8'h3C,8'h3C,8'hFF, 3'b111,8'h3C,1,0,3'b111,0,3'd2);
        for (int k = 0; k < 3; k++)
            addVec("vote_dis", 1,0, 8'h3C,8'h3C,8'hFF, 3'b111,8'h3C,1,0,3'b111,0,3'd2);
        addVec("retire2",  1,0, 8'h3C,8'h3C,8'hFF, 3'b011,8'h3C,1,0,3'b011,1,3'd3);
        addVec("dup_eq",   1,0, 8'h3C,8'h3C,8'hFF, 3'b011,8'h3C,1,0,3'b011,0,3'd3);
        addVec("dup_miss", 1,0, 8'h11,8'h12,8'hFF, 3'b011,8'h11,0,1,3'b011,0,3'd3);
        addVec("dup_match",1,0, 8'h11,8'h11,8'hFF, 3'b011,8'h11,1,0,3'b011,0,3'd3);
        addVec("clear1",   1,1, 8'h11,8'h11,8'h11, 3'b001,8'h11,1,0,3'b111,0,3'd0);

        // Leaky counter: replica 1 alternates, retires on the 13th vote cycle.
        addVec("to_warm_b",1,0, 8'h22,8'h22,8'h22, 3'b111,8'h22,1,0,3'b111,0,3'd1);
        for (int k = 0; k < 3; k++)
            addVec("warm_b", 1,0, 8'h22,8'h22,8'h22, 3'b111,8'h22,1,0,3'b111,0,3'd1);
        addVec("to_vote_b",1,0, 8'h22,8'h22,8'h22, 3'b111,8'h22,1,0,3'b111,0,3'd2);
        for (int k = 1; k <= 12; k++)
            addVec("leaky", 1,0, 8'h22, (k % 2 == 1) ? 8'h23 : 8'h22, 8'h22,
                   3'b111,8'h22,1,0,3'b111,0,3'd2);
        addVec("leaky_ret",1,0, 8'h22,8'h23,8'h22, 3'b101,8'h22,1,0,3'b101,1,3'd3);
        addVec("dup_b",    1,0, 8'h22,8'h99,8'h22, 3'b101,8'h22,1,0,3'b101,0,3'd3);
        addVec("clear2",   1,1, 8'h01,8'h02,8'h04, 3'b001,8'h01,0,1,3'b111,0,3'd0);

        // Total disagreement: all three retire together, FAIL, then clear.
        addVec("to_warm_c",1,0, 8'h01,8'h02,8'h04, 3'b111,8'h01,1,0,3'b111,0,3'd1);
        for (int k = 0; k < 3; k++)
            addVec("warm_c", 1,0, 8'h01,8'h02,8'h04, 3'b111,8'h01,1,0,3'b111,0,3'd1);
        addVec("to_vote_c",1,0, 8'h01,8'h02,8'h04, 3'b111,8'h01,1,0,3'b111,0,3'd2);
        for (int k = 0; k < 3; k++)
            addVec("all_bad", 1,0, 8'h01,8'h02,8'h04, 3'b111,8'h00,1,0,3'b111,0,3'd2);
        addVec("all_ret",  1,0, 8'h01,8'h02,8'h04, 3'b000,8'h00,1,0,3'b000,1,3'd4);
        addVec("fail",     1,0, 8'h55,8'h55,8'h55, 3'b000,8'h00,0,0,3'b000,0,3'd4);
        addVec("fail_clr", 1,1, 8'h55,8'h55,8'h55, 3'b001,8'h00,0,0,3'b111,0,3'd0);
        addVec("post_clr", 0,0, 8'h77,8'h00,8'h00, 3'b001,8'h77,1,0,3'b111,0,3'd0);

        // Reset state.
        applyStimulus(1, 0, 0, 8'h5A, 8'h00, 8'h00);
        applyStimulus(1, 0, 0, 8'h5A, 8'h00, 8'h00);
        checkOutput("reset", 3'b001, 8'h00, 0, 0, 3'b111, 0, 3'd0);

        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].hr, vecs[i].clr, vecs[i].r0, vecs[i].r1, vecs[i].r2);
            checkOutput(vecs[i].name, vecs[i].en, vecs[i].data, vecs[i].valid,
                        vecs[i].mis, vecs[i].hl, vecs[i].irq, vecs[i].mode);
        end

        // Reset on the edge where all three would retire: no partial retirement.
        for (int k = 0; k < 5; k++)
            applyStimulus(0, 1, 0, 8'h01, 8'h02, 8'h04);
        checkOutput("rst_vote", 3'b111, 8'h01, 1, 0, 3'b111, 0, 3'd2);
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 1, 0, 8'h01, 8'h02, 8'h04);
        applyStimulus(1, 1, 0, 8'h01, 8'h02, 8'h04);
        checkOutput("rst_mid", 3'b001, 8'h00, 0, 0, 3'b111, 0, 3'd0);
        applyStimulus(0, 1, 0, 8'h01, 8'h02, 8'h04);
        checkOutput("rst_after", 3'b111, 8'h01, 1, 0, 3'b111, 0, 3'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
